// File: rtl/reg_file_2w_pkg.sv
// Shared CPU register-file parameters and address helpers, reused by decode and hazard logic.
// Register-file sizing comes from here so that every consumer agrees on it.
package reg_file_2w_pkg;

    localparam int unsigned CpuDataWidth = 32;
    localparam int unsigned CpuRegDepth  = 32;

    // Address width for a register count; never narrower than one bit.
    function automatic int unsigned reg_addr_width(input int unsigned depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

    localparam int unsigned CpuRegAw = reg_addr_width(CpuRegDepth);

    // An address can hold state only if it is in range and is not a hard-wired zero register.
    function automatic logic reg_addr_writable(input int unsigned addr,
                                               input int unsigned depth,
                                               input bit          zero_r0);
        return (addr < depth) && !(zero_r0 && (addr == 0));
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending bits for hazard detection: reserve sets a bit, a register write clears it.
// When a set and a clear hit the same register in one cycle, the set wins.
module reg_scoreboard
    import reg_file_2w_pkg::*;
#(
    parameter int unsigned DEPTH   = CpuRegDepth,
    parameter int unsigned AW      = reg_addr_width(DEPTH),
    parameter bit          ZERO_R0 = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr0_en_i,
    input  logic [AW-1:0] clr0_addr_i,
    input  logic          clr1_en_i,
    input  logic [AW-1:0] clr1_addr_i,
    input  logic          set_en_i,
    input  logic [AW-1:0] set_addr_i,
    input  logic [AW-1:0] ra_i,
    input  logic [AW-1:0] rb_i,
    output logic          pend_a_o,
    output logic          pend_b_o
);

    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;
    logic             clr0_ok;
    logic             clr1_ok;
    logic             set_ok;

    assign clr0_ok = clr0_en_i && reg_addr_writable(32'(clr0_addr_i), DEPTH, ZERO_R0);
    assign clr1_ok = clr1_en_i && reg_addr_writable(32'(clr1_addr_i), DEPTH, ZERO_R0);
    assign set_ok  = set_en_i  && reg_addr_writable(32'(set_addr_i),  DEPTH, ZERO_R0);

    // Set is applied after both clears so it takes priority.
    always_comb begin
        pend_d = pend_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (clr0_ok && (clr0_addr_i == AW'(i))) begin
                pend_d[i] = 1'b0;
            end
            if (clr1_ok && (clr1_addr_i == AW'(i))) begin
                pend_d[i] = 1'b0;
            end
            if (set_ok && (set_addr_i == AW'(i))) begin
                pend_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Addresses at or beyond DEPTH match no entry and so report not pending.
    always_comb begin
        pend_a_o = 1'b0;
        pend_b_o = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ra_i == AW'(i)) begin
                pend_a_o = pend_q[i];
            end
            if (rb_i == AW'(i)) begin
                pend_b_o = pend_q[i];
            end
        end
    end

endmodule

// File: rtl/reg_file_2w.sv
// Two-write, two-read register file with registered, write-through read ports
// and a pending-bit scoreboard that drives the pipeline stall.
module reg_file_2w
    import reg_file_2w_pkg::*;
#(
    parameter int unsigned N       = CpuDataWidth,
    parameter int unsigned DEPTH   = CpuRegDepth,
    parameter int unsigned AW      = reg_addr_width(DEPTH),
    parameter bit          ZERO_R0 = 1'b1
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          RegWr0,
    input  logic [AW-1:0] Rw0,
    input  logic [N-1:0]  busW0,
    input  logic          RegWr1,
    input  logic [AW-1:0] Rw1,
    input  logic [N-1:0]  busW1,
    input  logic          RdEn,
    input  logic [AW-1:0] Ra,
    input  logic [AW-1:0] Rb,
    output logic [N-1:0]  busA,
    output logic [N-1:0]  busB,
    input  logic          Rsv,
    input  logic [AW-1:0] RsvAddr,
    output logic          PendA,
    output logic          PendB,
    output logic          Stall
);

    logic [N-1:0] regs_q [DEPTH];
    logic [N-1:0] busa_q;
    logic [N-1:0] busa_d;
    logic [N-1:0] busb_q;
    logic [N-1:0] busb_d;
    logic [N-1:0] stored_a;
    logic [N-1:0] stored_b;
    logic         wr0_ok;
    logic         wr1_ok;
    logic         zero_a;
    logic         zero_b;

    assign wr0_ok = RegWr0 && reg_addr_writable(32'(Rw0), DEPTH, ZERO_R0);
    assign wr1_ok = RegWr1 && reg_addr_writable(32'(Rw1), DEPTH, ZERO_R0);

    // Port 1 is checked first so it wins a same-address collision.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (wr1_ok && (Rw1 == AW'(i))) begin
                    regs_q[i] <= busW1;
                end else if (wr0_ok && (Rw0 == AW'(i))) begin
                    regs_q[i] <= busW0;
                end
            end
        end
    end

    always_comb begin
        stored_a = '0;
        stored_b = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (Ra == AW'(i)) begin
                stored_a = regs_q[i];
            end
            if (Rb == AW'(i)) begin
                stored_b = regs_q[i];
            end
        end
    end

    assign zero_a = ZERO_R0 && (Ra == '0);
    assign zero_b = ZERO_R0 && (Rb == '0);

    // Write-through: a same-cycle write is visible to the read captured at this edge.
    always_comb begin
        busa_d = stored_a;
        if (zero_a) begin
            busa_d = '0;
        end else if (wr1_ok && (Rw1 == Ra)) begin
            busa_d = busW1;
        end else if (wr0_ok && (Rw0 == Ra)) begin
            busa_d = busW0;
        end

        busb_d = stored_b;
        if (zero_b) begin
            busb_d = '0;
        end else if (wr1_ok && (Rw1 == Rb)) begin
            busb_d = busW1;
        end else if (wr0_ok && (Rw0 == Rb)) begin
            busb_d = busW0;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            busa_q <= '0;
            busb_q <= '0;
        end else if (RdEn) begin
            busa_q <= busa_d;
            busb_q <= busb_d;
        end
    end

    assign busA = busa_q;
    assign busB = busb_q;

    reg_scoreboard #(
        .DEPTH   (DEPTH),
        .AW      (AW),
        .ZERO_R0 (ZERO_R0)
    ) u_scoreboard (
        .clk_i       (Clk),
        .rst_i       (Rst),
        .clr0_en_i   (RegWr0),
        .clr0_addr_i (Rw0),
        .clr1_en_i   (RegWr1),
        .clr1_addr_i (Rw1),
        .set_en_i    (Rsv),
        .set_addr_i  (RsvAddr),
        .ra_i        (Ra),
        .rb_i        (Rb),
        .pend_a_o    (PendA),
        .pend_b_o    (PendB)
    );

    assign Stall = PendA | PendB;

endmodule

// File: tb/tb_reg_file_2w.sv
// Directed-vector bench for reg_file_2w: writes, collisions, forwarding, r0, scoreboard, async reset.
module tb_reg_file_2w;

    logic        Clk;
    logic        Rst;
    logic        RegWr0;
    logic [4:0]  Rw0;
    logic [31:0] busW0;
    logic        RegWr1;
    logic [4:0]  Rw1;
    logic [31:0] busW1;
    logic        RdEn;
    logic [4:0]  Ra;
    logic [4:0]  Rb;
    logic [31:0] busA;
    logic [31:0] busB;
    logic        Rsv;
    logic [4:0]  RsvAddr;
    logic        PendA;
    logic        PendB;
    logic        Stall;

    int n_vec = 0;
    int n_err = 0;

    reg_file_2w dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .RegWr0  (RegWr0),
        .Rw0     (Rw0),
        .busW0   (busW0),
        .RegWr1  (RegWr1),
        .Rw1     (Rw1),
        .busW1   (busW1),
        .RdEn    (RdEn),
        .Ra      (Ra),
        .Rb      (Rb),
        .busA    (busA),
        .busB    (busB),
        .Rsv     (Rsv),
        .RsvAddr (RsvAddr),
        .PendA   (PendA),
        .PendB   (PendB),
        .Stall   (Stall)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        RegWr0 = 1'b0;
        RegWr1 = 1'b0;
        Rsv    = 1'b0;
    endtask

    initial begin
        Rst = 1'b1;
        RegWr0 = 1'b0; Rw0 = '0; busW0 = '0;
        RegWr1 = 1'b0; Rw1 = '0; busW1 = '0;
        RdEn = 1'b0; Ra = '0; Rb = '0;
        Rsv = 1'b0; RsvAddr = '0;

        #12;
        check("rst_busA", busA, 32'h0);
        check("rst_busB", busB, 32'h0);
        step();
        Rst = 1'b0;

        // Reset then read
        RdEn = 1'b1; Ra = 5'd5; Rb = 5'd31;
        step();
        check("rd_after_rst_A", busA, 32'h0);
        check("rd_after_rst_B", busB, 32'h0);
        check("rd_after_rst_stall", 32'(Stall), 32'h0);

        // Dual-write collision on r3: port 1 wins
        RdEn = 1'b0;
        RegWr0 = 1'b1; Rw0 = 5'd3; busW0 = 32'h12;
        RegWr1 = 1'b1; Rw1 = 5'd3; busW1 = 32'h24;
        step();
        Rw0 = 5'd1; busW0 = 32'h12;
        Rw1 = 5'd2; busW1 = 32'h24;
        RdEn = 1'b1; Ra = 5'd3; Rb = 5'd0;
        step();
        check("collide_A", busA, 32'h24);
        check("collide_B_r0", busB, 32'h0);

        // Forwarding from both write ports
        Rw0 = 5'd4; busW0 = 32'h63;
        Rw1 = 5'd3; busW1 = 32'h102;
        Ra = 5'd4; Rb = 5'd3;
        step();
        check("fwd_port0_A", busA, 32'h63);
        check("fwd_port1_B", busB, 32'h102);

        idle();
        Ra = 5'd1; Rb = 5'd2;
        step();
        check("read_r1", busA, 32'h12);
        check("read_r2", busB, 32'h24);

        // RdEn low: outputs hold
        RdEn = 1'b0; Ra = 5'd4; Rb = 5'd3;
        step();
        check("hold_A", busA, 32'h12);
        check("hold_B", busB, 32'h24);

        // r0 ignores write and reserve
        RegWr1 = 1'b1; Rw1 = 5'd0; busW1 = 32'hFFFF_FFFF;
        Rsv = 1'b1; RsvAddr = 5'd0;
        RdEn = 1'b1; Ra = 5'd0; Rb = 5'd4;
        step();
        check("r0_fwd_A", busA, 32'h0);
        check("r0_read_r4", busB, 32'h63);
        check("r0_pendA", 32'(PendA), 32'h0);
        idle();
        step();
        check("r0_stored_A", busA, 32'h0);
        check("r0_pendA_late", 32'(PendA), 32'h0);

        // Scoreboard on r7
        RdEn = 1'b0;
        Rsv = 1'b1; RsvAddr = 5'd7; Ra = 5'd7; Rb = 5'd1;
        #1;
        check("sb_pend_before_edge", 32'(PendA), 32'h0);
        step();
        idle();
        #1;
        check("sb_pendA_set", 32'(PendA), 32'h1);
        check("sb_stall_set", 32'(Stall), 32'h1);
        check("sb_pendB_clear", 32'(PendB), 32'h0);

        RegWr0 = 1'b1; Rw0 = 5'd7; busW0 = 32'h77;
        Rsv = 1'b1; RsvAddr = 5'd7;
        step();
        idle();
        #1;
        check("sb_set_beats_clear", 32'(PendA), 32'h1);

        RegWr1 = 1'b1; Rw1 = 5'd7; busW1 = 32'h78;
        #1;
        check("sb_clear_not_fwd", 32'(PendA), 32'h1);
        step();
        idle();
        #1;
        check("sb_cleared", 32'(PendA), 32'h0);
        check("sb_stall_cleared", 32'(Stall), 32'h0);

        // Reserve r2 and load the read registers
        Rsv = 1'b1; RsvAddr = 5'd2;
        step();
        idle();
        RdEn = 1'b1; Ra = 5'd2; Rb = 5'd4;
        step();
        check("pre_rst_A", busA, 32'h24);
        check("pre_rst_B", busB, 32'h63);
        check("pre_rst_pendA", 32'(PendA), 32'h1);

        // Async reset between edges with a write and reserve in flight
        #3;
        RegWr0 = 1'b1; Rw0 = 5'd5; busW0 = 32'hAB;
        Rsv = 1'b1; RsvAddr = 5'd9;
        RdEn = 1'b1; Ra = 5'd2; Rb = 5'd9;
        Rst = 1'b1;
        #1;
        check("async_rst_A", busA, 32'h0);
        check("async_rst_B", busB, 32'h0);
        check("async_rst_pendA", 32'(PendA), 32'h0);
        check("async_rst_stall", 32'(Stall), 32'h0);
        step();
        check("rst_edge_A", busA, 32'h0);
        check("rst_edge_pendB", 32'(PendB), 32'h0);

        Rst = 1'b0;
        idle();
        RdEn = 1'b0; Ra = 5'd9; Rb = 5'd2;
        #1;
        check("rst_rsv_ignored", 32'(PendA), 32'h0);
        RdEn = 1'b1; Ra = 5'd5; Rb = 5'd1;
        step();
        check("rst_write_dropped", busA, 32'h0);
        check("rst_regs_cleared", busB, 32'h0);

        // Normal operation resumes after reset
        RegWr0 = 1'b1; Rw0 = 5'd5; busW0 = 32'h55;
        RdEn = 1'b0;
        step();
        idle();
        RdEn = 1'b1; Ra = 5'd5; Rb = 5'd7;
        step();
        check("resume_A", busA, 32'h55);
        check("resume_r7_cleared", busB, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_file_2w.md
REG_FILE_2W -- requirements
Module: reg_file_2w

Interface
REQ-001 Parameters SHALL be:
- N, 32, data width.
- DEPTH, 32, register count (power of two, >= 2).
- AW, log2(DEPTH), address width.
- ZERO_R0, 1, register 0 reads 0 and ignores writes.

REQ-002 Ports SHALL be:
- Clk  in  1  single clock; all state updates on rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- RegWr0  in  1  write enable, port 0.
- Rw0  in  AW  write address, port 0.
- busW0  in  N  write data, port 0.
- RegWr1  in  1  write enable, port 1.
- Rw1  in  AW  write address, port 1.
- busW1  in  N  write data, port 1.
- RdEn  in  1  read enable; output registers update only when high.
- Ra  in  AW  read address A.
- Rb  in  AW  read address B.
- busA  out  N  registered read data A.
- busB  out  N  registered read data B.
- Rsv  in  1  reserve request (mark a register pending).
- RsvAddr  in  AW  register to reserve.
- PendA  out  1  combinational: register Ra pending.
- PendB  out  1  combinational: register Rb pending.
- Stall  out  1  combinational: PendA or PendB.

Function
REQ-003 Writes SHALL commit on the rising Clk edge when the port's enable is high.
REQ-004 When both ports write the same address in one cycle, port 1 data SHALL win.
REQ-005 With ZERO_R0=1, writes to address 0 SHALL be dropped and reads of address 0 SHALL return 0.
REQ-006 Reads SHALL have 1-cycle latency: with RdEn high at edge k, busA/busB SHALL present data at edge k; with RdEn low they SHALL hold.
REQ-007 Read data SHALL be write-through forwarded: if Ra (or Rb) matches an enabled write address in the same cycle, busA (or busB) SHALL capture that write data, using REQ-004 priority; address 0 SHALL still return 0 when ZERO_R0=1.
REQ-008 Each register SHALL have a pending bit.
REQ-009 Rsv SHALL set pending[RsvAddr] at the edge.
REQ-010 Any enabled write SHALL clear pending[Rw] at the edge.
REQ-011 If Rsv and a write target the same address in one cycle, set SHALL win and the bit SHALL end pending.
REQ-012 Reserving address 0 SHALL be ignored when ZERO_R0=1.
REQ-013 PendA SHALL equal pending[Ra] and SHALL NOT be forwarded; a same-cycle clearing write is not seen until the next cycle. PendB SHALL behave likewise for Rb.
REQ-014 Out-of-range addresses (DEPTH below 2^AW) SHALL read 0; writes and reserves to them SHALL be ignored.

Reset
REQ-015 Rst high SHALL asynchronously clear all registers, all pending bits, busA and busB to 0, regardless of Clk.
REQ-016 Writes, reserves and RdEn SHALL have no effect while Rst is high.
REQ-017 Operation SHALL resume on the first rising edge after Rst falls.
REQ-018 Rst asserted mid-operation SHALL discard the in-flight write.

Structure
REQ-019 N default, DEPTH default and the AW derivation SHALL live in the shared CPU package for reuse by decode and hazard logic.
REQ-020 The pending-bit array with its set/clear priority SHALL be one sub-module, reg_scoreboard; storage and forwarding SHALL stay in reg_file_2w.

Verification
REQ-021 Reset then read: Rst pulse, then RdEn=1, Ra=5, Rb=31 -> busA=0, busB=0, Stall=0.
REQ-022 Dual-write collision: RegWr0=RegWr1=1, Rw0=Rw1=3, busW0=0x12, busW1=0x24; next cycle Ra=3 -> busA=0x24.
REQ-023 Forwarding: RegWr0=1, Rw0=4, busW0=0x63, with Ra=4, RdEn=1 in the same cycle -> busA=0x63 after that edge.
REQ-024 r0: RegWr1=1, Rw1=0, busW1=0xFFFFFFFF and Rsv=1, RsvAddr=0 -> busA=0 for Ra=0, PendA=0.
REQ-025 Scoreboard: Rsv at address 7 -> PendA=1 and Stall=1 for Ra=7. Write to 7 in the same cycle as a new Rsv to 7 -> still pending. A later write alone to 7 -> PendA=0 the following cycle.
REQ-026 Async reset: assert Rst between edges with registers 1-4 holding 0x12, 0x24, 0x102, 0x63 and pending[2]=1 -> busA/busB and pending clear immediately, with no Clk edge needed.
